// File: rtl/product_display_pkg.sv
// rtl/product_display_pkg.sv - shared types, constants and helpers for the product BCD display
package product_display_pkg;

    // Handshake / conversion FSM
    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    // Which of the three display positions is currently driven
    typedef enum logic [1:0] {
        ONES     = 2'd0,
        TENS     = 2'd1,
        HUNDREDS = 2'd2
    } digit_idx_t;

    localparam int DATA_W   = 8;
    localparam int BCD_W    = 12;
    localparam int ITER_W   = 3;
    localparam int REFRESH_W = 16;

    // Seven-segment codes {g,f,e,d,c,b,a}, entry n is the glyph for digit n
    localparam logic [9:0][6:0] SEG_CODES = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Glyph lookup; anything outside 0..9 renders dark rather than garbage
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_CODES[d];
    endfunction

    // Double-dabble correction so the following left shift carries decimally
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Scan order: ones -> tens -> hundreds -> ones
    function automatic digit_idx_t next_digit(input digit_idx_t d);
        case (d)
            ONES:    return TENS;
            TENS:    return HUNDREDS;
            default: return ONES;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 8-bit sequential double-dabble, one step per enabled cycle
module bin2bcd_seq
    import product_display_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    logic [DATA_W-1:0]       shift_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [ITER_W-1:0]       iter_q;
    logic                    active_q;

    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+DATA_W-1:0] dd_word;
    logic [BCD_W-1:0]        bcd_step;
    logic [DATA_W-1:0]       shift_step;
    logic                    last_step;

    // One double-dabble step: correct every nibble, then shift {bcd, shift} left
    always_comb begin
        bcd_adj    = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
        dd_word    = {bcd_adj, shift_q} << 1;
        bcd_step   = dd_word[BCD_W+DATA_W-1:DATA_W];
        shift_step = dd_word[DATA_W-1:0];
        last_step  = active_q && (iter_q == ITER_W'(7));
    end

    // The result of the 8th step is offered combinationally so the caller can
    // capture it on the same edge that performs that step
    assign done = ena & last_step;
    assign bcd  = bcd_step;

    // Load on start, then iterate eight times; everything holds while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
        end else if (ena) begin
            if (start) begin
                shift_q  <= data;
                bcd_q    <= '0;
                iter_q   <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                shift_q <= shift_step;
                bcd_q   <= bcd_step;
                iter_q  <= iter_q + ITER_W'(1);
                if (last_step) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - product to three-digit multiplexed seven-segment display
module product_bcd_display
    import product_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [6:0]        seg,
    output logic [2:0]        digit_sel,
    output logic              busy
);

    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

    state_t                state_q;
    state_t                state_d;
    logic                  handshake;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic [BCD_W-1:0]      disp_q;
    logic [REFRESH_W-1:0]  refresh_q;
    digit_idx_t            digit_q;

    logic [3:0]            ones_d;
    logic [3:0]            tens_d;
    logic [3:0]            hund_d;
    logic [3:0]            nib;
    logic                  blank;

    assign handshake = in_valid & in_ready;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (handshake),
        .data  (in_data),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Next state and handshake outputs; in_ready already folds in ena, so a
    // disabled cycle can neither accept nor finish a conversion
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ena;
                if (in_valid && ena) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (conv_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Display register only changes when a conversion completes, so the old
    // value stays visible for the whole conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
        end
    end

    // Refresh divider and digit scan, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            digit_q   <= ONES;
        end else if (ena) begin
            if (refresh_q == REFRESH_LAST) begin
                refresh_q <= '0;
                digit_q   <= next_digit(digit_q);
            end else begin
                refresh_q <= refresh_q + REFRESH_W'(1);
            end
        end
    end

    // Segment decode with leading-zero blanking; a blanked digit keeps its select
    always_comb begin
        ones_d    = disp_q[3:0];
        tens_d    = disp_q[7:4];
        hund_d    = disp_q[11:8];
        nib       = ones_d;
        blank     = 1'b0;
        digit_sel = 3'b001;
        case (digit_q)
            TENS: begin
                nib       = tens_d;
                blank     = (hund_d == 4'd0) && (tens_d == 4'd0);
                digit_sel = 3'b010;
            end
            HUNDREDS: begin
                nib       = hund_d;
                blank     = (hund_d == 4'd0);
                digit_sel = 3'b100;
            end
            default: begin
                nib       = ones_d;
                blank     = 1'b0;
                digit_sel = 3'b001;
            end
        endcase
        seg = blank ? SEG_BLANK : seg_code(nib);
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - self-checking bench for product_bcd_display
module tb_product_bcd_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] seg;
    logic [2:0] digit_sel;
    logic       busy;

    product_bcd_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg       (seg),
        .digit_sel (digit_sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] value;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] hund;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a value and wait for the handshake edge; the expectation is queued then
    task automatic send(input vec_t v, output int waited);
        in_data  = v.value;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
        end else begin
            tick();
            exp_q.push_back(v);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
        if (busy) fail_now("done_timeout");
    endtask

    task automatic check_digit(input vec_t e, input string tag);
        case (digit_sel)
            3'b001:  check({tag, "_ones"}, seg, e.ones);
            3'b010:  check({tag, "_tens"}, seg, e.tens);
            3'b100:  check({tag, "_hund"}, seg, e.hund);
            default: check({tag, "_onehot"}, digit_sel, 3'b001);
        endcase
    endtask

    task automatic scan(input vec_t e, input string tag);
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            check_digit(e, tag);
        end
    endtask

    // Wait for completion, pop the scoreboard and check the displayed value
    task automatic complete(input int exp_cycles, input bit full_scan, input string tag);
        int   c;
        vec_t e;
        wait_done(c);
        check({tag, "_latency"}, c, exp_cycles);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        if (exp_q.size() == 0) begin
            fail_now({tag, "_sb_empty"});
        end else begin
            e = exp_q.pop_front();
            check_digit(e, {tag, "_first"});
            if (full_scan) scan(e, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        vec_t v50, v77, v143, v255, v0;
        logic [2:0] sel_hold;
        logic [6:0] seg_hold;

        vecs[0] = '{8'd225, 7'h6D, 7'h5B, 7'h5B};
        vecs[1] = '{8'd12,  7'h5B, 7'h06, 7'h00};
        vecs[2] = '{8'd35,  7'h6D, 7'h4F, 7'h00};
        vecs[3] = '{8'd0,   7'h3F, 7'h00, 7'h00};
        vecs[4] = '{8'd100, 7'h3F, 7'h3F, 7'h06};
        vecs[5] = '{8'd9,   7'h6F, 7'h00, 7'h00};
        vecs[6] = '{8'd208, 7'h7F, 7'h3F, 7'h5B};
        v50  = '{8'd50,  7'h3F, 7'h6D, 7'h00};
        v77  = '{8'd77,  7'h07, 7'h07, 7'h00};
        v143 = '{8'd143, 7'h4F, 7'h66, 7'h06};
        v255 = '{8'd255, 7'h6D, 7'h6D, 7'h5B};
        v0   = '{8'd0,   7'h3F, 7'h00, 7'h00};

        // Reset state and idle scan
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        for (int i = 0; i < 3 * DIV; i++) begin
            check("rst_sel", digit_sel, (i < DIV) ? 3'b001 : (i < 2 * DIV) ? 3'b010 : 3'b100);
            check("rst_seg", seg, (i < DIV) ? 7'h3F : 7'h00);
            tick();
        end

        // Table-driven conversions
        for (int i = 0; i < 7; i++) begin
            send(vecs[i], w);
            in_valid = 1'b0;
            complete(8, 1'b1, "vec");
        end

        // in_valid held through CONVERT with a different value; accepted back-to-back
        send(v50, w);
        in_data = 8'd77;
        complete(8, 1'b0, "held50");
        send(v77, w);
        check("back_to_back_wait", w, 0);
        in_valid = 1'b0;
        complete(8, 1'b1, "held77");

        // ena dropped for three cycles mid-conversion
        send(v143, w);
        in_valid = 1'b0;
        repeat (3) tick();
        ena = 1'b0;
        sel_hold = digit_sel;
        seg_hold = seg;
        repeat (3) begin
            tick();
            check("ena_in_ready", in_ready, 1'b0);
            check("ena_busy", busy, 1'b1);
            check("ena_sel_hold", digit_sel, sel_hold);
            check("ena_seg_hold", seg, seg_hold);
        end
        ena = 1'b1;
        complete(5, 1'b1, "ena143");

        // Reset during the fourth step of converting 255
        send(v255, w);
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_seg", seg, 7'h3F);
        check("abort_sel", digit_sel, 3'b001);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check_digit(v0, "abort_first");
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            check_digit(v0, "abort_scan");
            check("abort_idle", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
